// File: rtl/ip_mem_loader.sv
// Runtime program loader for the instruction RAM. It takes a stream of instruction
// words and writes them to consecutive BCD addresses through the request/ready port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Start; the start address is validated here
// LOAD  | InReady high, capturing the next stream word
// REQ   | single-cycle write request to memory
// WAIT  | guard cycle, then wait for MemReady or the timeout
// DONE  | one-cycle Done pulse after the final word
module ip_mem_loader #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_WIDTH = 4,
  parameter int INSN_WIDTH  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Start,
  input  logic [DIGITS*DIGIT_WIDTH-1:0] StartAddr,
  input  logic                          InValid,
  input  logic [INSN_WIDTH-1:0]         InData,
  input  logic                          InLast,
  output logic                          InReady,
  output logic                          MemRequest,
  output logic                          MemWE,
  output logic [DIGITS*DIGIT_WIDTH-1:0] MemAddress,
  output logic [INSN_WIDTH-1:0]         MemInsnIn,
  input  logic                          MemReady,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Error
);

  localparam int AW = DIGITS * DIGIT_WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DIGIT_WIDTH-1:0] NINE = DIGIT_WIDTH'(9);
  localparam logic [DIGIT_WIDTH-1:0] ONE  = DIGIT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         addr_inc;
  logic [INSN_WIDTH-1:0] insn_q;
  logic                  last_q;
  logic                  error_q;
  logic [CW-1:0]         wait_cnt;
  logic                  start_ok;
  logic                  carry;
  logic                  wr_done;
  logic                  wait_to;

  always_comb begin
    start_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (StartAddr[i*DIGIT_WIDTH +: DIGIT_WIDTH] > NINE) start_ok = 1'b0;
    end
  end

  // Ripple-carry BCD +1; all nines rolls over to all zeros.
  always_comb begin
    addr_inc = addr_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (addr_q[i*DIGIT_WIDTH +: DIGIT_WIDTH] == NINE) begin
          addr_inc[i*DIGIT_WIDTH +: DIGIT_WIDTH] = '0;
        end else begin
          addr_inc[i*DIGIT_WIDTH +: DIGIT_WIDTH] = addr_q[i*DIGIT_WIDTH +: DIGIT_WIDTH] + ONE;
          carry = 1'b0;
        end
      end
    end
  end

  // wait_cnt == 0 marks the guard cycle, where a stale Ready from before the request is ignored.
  assign wr_done = (state_q == ST_WAIT) && (wait_cnt != '0) && MemReady;
  assign wait_to = (state_q == ST_WAIT) && !wr_done && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    InReady    = 1'b0;
    MemRequest = 1'b0;
    MemWE      = 1'b0;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        Busy = 1'b0;
        if (Start && start_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        InReady = 1'b1;
        if (InValid) state_d = ST_REQ;
      end
      ST_REQ: begin
        MemRequest = 1'b1;
        MemWE      = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wr_done)      state_d = last_q ? ST_DONE : ST_LOAD;
        else if (wait_to) state_d = ST_IDLE;
      end
      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      insn_q   <= '0;
      last_q   <= 1'b0;
      error_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && Start) begin
        if (start_ok) begin
          addr_q  <= StartAddr;
          error_q <= 1'b0;
        end else begin
          error_q <= 1'b1;
        end
      end
      if (state_q == ST_LOAD && InValid) begin
        insn_q <= InData;
        last_q <= InLast;
      end
      if (state_q == ST_REQ) begin
        wait_cnt <= '0;
      end else if (state_q == ST_WAIT && wait_cnt != CW'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wr_done) addr_q <= addr_inc;
      if (wait_to) error_q <= 1'b1;
    end
  end

  assign MemAddress = addr_q;
  assign MemInsnIn  = insn_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_ip_mem_loader.sv
// Bench for ip_mem_loader: behavioural memory responder, decimal address model,
// and directed plus randomized load sessions.
module tb_ip_mem_loader;

  localparam int DIGITS = 6;
  localparam int DW     = 4;
  localparam int IW     = 4;
  localparam int TO     = 16;
  localparam int AW     = DIGITS * DW;
  localparam int MOD    = 1000000;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic [AW-1:0] StartAddr = '0;
  logic          InValid = 1'b0;
  logic [IW-1:0] InData = '0;
  logic          InLast = 1'b0;
  logic          InReady;
  logic          MemRequest;
  logic          MemWE;
  logic [AW-1:0] MemAddress;
  logic [IW-1:0] MemInsnIn;
  logic          MemReady = 1'b1;
  logic          Busy;
  logic          Done;
  logic          Error;

  int errors = 0;
  int checks = 0;

  ip_mem_loader #(.DIGITS(DIGITS), .DIGIT_WIDTH(DW), .INSN_WIDTH(IW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .StartAddr(StartAddr),
    .InValid(InValid), .InData(InData), .InLast(InLast), .InReady(InReady),
    .MemRequest(MemRequest), .MemWE(MemWE), .MemAddress(MemAddress),
    .MemInsnIn(MemInsnIn), .MemReady(MemReady), .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  wr_t           wr_q[$];
  logic [IW-1:0] mem [logic [AW-1:0]];
  int            mem_mode = 0;    // 0: ready 2 cycles after request, 1: stalled, 2: ready only in guard cycle
  int            rc = 1000;
  int            done_cnt = 0;
  int            proto_viol = 0;
  logic          prev_req = 1'b0;

  // Memory responder and protocol monitor, evaluated mid-cycle.
  always @(negedge Clk) begin
    wr_t w;
    if (MemRequest) begin
      if (MemWE) begin
        mem[MemAddress] = MemInsnIn;
        w.a = MemAddress;
        w.d = MemInsnIn;
        wr_q.push_back(w);
      end
      rc = 0;
    end else if (rc < 1000) begin
      rc++;
    end
    case (mem_mode)
      0:       MemReady = (rc >= 2);
      1:       MemReady = 1'b0;
      default: MemReady = (rc == 1);
    endcase
    if (Done) done_cnt++;
    if ((MemWE && !MemRequest) || (MemRequest && prev_req) ||
        (InReady && (!Busy || MemRequest || Done))) begin
      proto_viol++;
      if (proto_viol <= 5)
        $display("FAIL protocol at %0t: req=%b we=%b prev_req=%b inready=%b busy=%b done=%b",
                 $time, MemRequest, MemWE, prev_req, InReady, Busy, Done);
    end
    prev_req = MemRequest;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int bcd2int(input logic [AW-1:0] a);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(a[i*DW +: DW]);
    return v;
  endfunction

  function automatic logic [AW-1:0] int2bcd(input int v);
    logic [AW-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] sa, input int i);
    return int2bcd((bcd2int(sa) + i) % MOD);
  endfunction

  function automatic logic [AW-1:0] rand_bcd();
    logic [AW-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*DW +: DW] = DW'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input bit last, input bit gaps,
                           input bit poke, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      InData  = d;
      InLast  = last;
      InValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        Start     = 1'($urandom_range(0, 1));
        StartAddr = rand_bcd();
      end
      @(negedge Clk);
      acc = InReady && InValid;
      tick();
      if (acc) ok = 1'b1;
    end
    InValid = 1'b0;
    Start   = 1'b0;
  endtask

  task automatic run_session(input logic [AW-1:0] sa, input logic [IW-1:0] data[$],
                             input bit gaps, input bit poke, input string name);
    int w0, d0, k, n;
    bit ok;
    n  = data.size();
    w0 = wr_q.size();
    d0 = done_cnt;
    StartAddr = sa;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_word(data[i], i == n - 1, gaps, poke, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s word_accept: word %0d not accepted within 200 cycles", name, i);
        return;
      end
    end
    k = 0;
    while (Busy && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_return: busy=%b expected 0", name, Busy);
    end
    checks++;
    if (wr_q.size() - w0 !== n) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size() - w0, n);
    end
    for (int i = 0; i < n && w0 + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[w0+i].a !== exp_addr(sa, i) || wr_q[w0+i].d !== data[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got (%h,%h) expected (%h,%h)", name, i,
                 wr_q[w0+i].a, wr_q[w0+i].d, exp_addr(sa, i), data[i]);
      end
      checks++;
      if (!mem.exists(exp_addr(sa, i)) || mem[exp_addr(sa, i)] !== data[i]) begin
        errors++;
        $display("FAIL %s readback[%0d]: address %h missing or wrong, expected %h",
                 name, i, exp_addr(sa, i), data[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
    end
    checks++;
    if (Error !== 1'b0) begin
      errors++;
      $display("FAIL %s error_flag: got %b expected 0", name, Error);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({InReady, MemRequest, MemWE, Busy, Done, Error} !== 6'b0) begin
      errors++;
      $display("FAIL %s ctrl: {inready,req,we,busy,done,error}=%b expected 000000", name,
               {InReady, MemRequest, MemWE, Busy, Done, Error});
    end
    checks++;
    if (MemAddress !== '0 || MemInsnIn !== '0) begin
      errors++;
      $display("FAIL %s data: addr=%h insn=%h expected 0/0", name, MemAddress, MemInsnIn);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_three_word();
    logic [IW-1:0] q[$];
    q = '{4'h3, 4'h7, 4'hA};
    run_session(24'h000120, q, 1'b0, 1'b0, "three_word");
  endtask

  task automatic test_carry_wrap();
    logic [IW-1:0] q[$];
    q = '{IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15))};
    run_session(24'h000099, q, 1'b0, 1'b0, "carry");
    q = '{IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15))};
    run_session(24'h999999, q, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_timing();
    StartAddr = 24'h000500;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL timing load_after_start: inready=%b expected 1", InReady);
    end
    InValid = 1'b1; InData = 4'h5; InLast = 1'b0;
    tick();
    InValid = 1'b0;
    checks++;
    if (MemRequest !== 1'b1 || MemWE !== 1'b1 || MemAddress !== 24'h000500 || MemInsnIn !== 4'h5) begin
      errors++;
      $display("FAIL timing request: req=%b we=%b addr=%h insn=%h expected 1 1 000500 5",
               MemRequest, MemWE, MemAddress, MemInsnIn);
    end
    tick();
    tick();
    checks++;
    if (MemRequest !== 1'b0 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL timing wait: req=%b inready=%b expected 0 0", MemRequest, InReady);
    end
    tick();
    checks++;
    if (InReady !== 1'b1 || MemAddress !== 24'h000501) begin
      errors++;
      $display("FAIL timing next_load: inready=%b addr=%h expected 1 000501", InReady, MemAddress);
    end
    InValid = 1'b1; InData = 4'h9; InLast = 1'b1;
    tick();
    InValid = 1'b0; InLast = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL timing done: done=%b busy=%b expected 1 1", Done, Busy);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || MemAddress !== 24'h000502) begin
      errors++;
      $display("FAIL timing idle: done=%b busy=%b addr=%h expected 0 0 000502", Done, Busy, MemAddress);
    end
  endtask

  task automatic test_bad_addr();
    int w0;
    logic [IW-1:0] q[$];
    w0 = wr_q.size();
    StartAddr = 24'h00012A;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr flag: error=%b busy=%b inready=%b expected 1 0 0", Error, Busy, InReady);
    end
    tick();
    tick();
    checks++;
    if (wr_q.size() !== w0 || Busy !== 1'b0 || Error !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr quiet: writes=%0d busy=%b error=%b expected %0d 0 1",
               wr_q.size(), Busy, Error, w0);
    end
    q = '{4'h2};
    run_session(24'h000300, q, 1'b0, 1'b0, "bad_addr_recover");
  endtask

  task automatic test_stall();
    int d0;
    for (int m = 1; m <= 2; m++) begin
      mem_mode = m;
      d0 = done_cnt;
      StartAddr = (m == 1) ? 24'h000700 : 24'h000710;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++;
      if (Error !== 1'b0 || InReady !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d start: error=%b inready=%b expected 0 1", m, Error, InReady);
      end
      InValid = 1'b1; InData = 4'hC; InLast = 1'b1;
      tick();
      InValid = 1'b0; InLast = 1'b0;
      repeat (TO) tick();
      checks++;
      if (Error !== 1'b0 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d last_wait: error=%b busy=%b expected 0 1", m, Error, Busy);
      end
      tick();
      checks++;
      if (Error !== 1'b1 || Busy !== 1'b0 || done_cnt !== d0 ||
          MemAddress !== ((m == 1) ? 24'h000700 : 24'h000710)) begin
        errors++;
        $display("FAIL stall%0d timeout: error=%b busy=%b done_pulses=%0d addr=%h expected 1 0 0 unchanged",
                 m, Error, Busy, done_cnt - d0, MemAddress);
      end
    end
    mem_mode = 0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] q[$];
    int n;
    for (int s = 0; s < 6; s++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) q.push_back(IW'($urandom_range(0, 15)));
      run_session(rand_bcd(), q, 1'b1, 1'b1, "random");
    end
    checks++;
    if (proto_viol !== 0) begin
      errors++;
      $display("FAIL protocol_total: violations=%0d expected 0", proto_viol);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [IW-1:0] q[$];
    StartAddr = 24'h000800;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    InValid = 1'b1; InData = 4'h6; InLast = 1'b0;
    tick();
    InValid = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_reset_values("reset_mid_wait");
    q = '{IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15))};
    run_session(24'h000810, q, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_carry_wrap();
    test_timing();
    test_bad_addr();
    test_stall();
    test_back_to_back();
    test_reset_mid_wait();
    checks++;
    if (proto_viol !== 0) begin
      errors++;
      $display("FAIL protocol_final: violations=%0d expected 0", proto_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
